immediate_materializer: RTL
===========================

Name: immediate_materializer

Overview:
Inverse of the decode-side 12-bit immediate sign-extender. It takes a full 32-bit constant and a destination register, and emits the minimal RV32I instruction sequence that loads that constant: one ADDI, one LUI, or a LUI+ADDI pair. It sits in the instruction-injection path (boot ROM patcher, debug/test stimulus). Constants arrive on a valid/ready input and instruction words leave on a valid/ready output stream.

Parameters:
XLEN, 32, constant and instruction width; only 32 is supported.
SHORT_FORM, 1, 1 = use single-instruction forms where legal; 0 = always emit LUI+ADDI.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  constant request valid.
in_ready  output  1  block can accept a request.
in_value  input  32  constant to materialize.
in_rd  input  5  destination register index.
out_valid  output  1  out_instr is valid.
out_ready  input  1  downstream accepts out_instr.
out_instr  output  32  encoded RV32I instruction.
out_last  output  1  marks the final instruction of the current sequence.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset: state = IDLE; out_valid = 0; out_instr = 0; out_last = 0; busy = 0; in_ready = 1 after rst_n deasserts.
- in_ready = (state == IDLE), combinational from state only. It never depends on in_valid.
- Accept occurs when in_valid && in_ready. On accept, register in_value and in_rd, then classify:
  - SHORT: SHORT_FORM=1 and in_value[31:11] all equal (fits signed 12-bit). Emit ADDI rd, x0, in_value[11:0].
  - LUI_ONLY: not SHORT, SHORT_FORM=1, and in_value[11:0] == 0. Emit LUI rd, in_value[31:12].
  - PAIR: all other cases. Compute hi = (in_value[31:12] + in_value[11]) mod 2^20 and lo = in_value[11:0]. Emit LUI rd, hi, then ADDI rd, rd, lo.
  - Exception: if in_rd == 0, the request is accepted and dropped. No output is produced and state stays IDLE.
- Encodings:
  - LUI = {imm20, rd, 7'b0110111}.
  - ADDI = {imm12, rs1, 3'b000, rd, 7'b0010011}.
- States:
  - IDLE. On accept with rd != 0: go to EMIT_LO for SHORT; go to EMIT_HI for LUI_ONLY or PAIR.
  - EMIT_HI. Drives LUI. out_last = 1 for LUI_ONLY, 0 for PAIR. On handshake: go to IDLE (LUI_ONLY) or EMIT_LO (PAIR).
  - EMIT_LO. Drives ADDI with rs1 = x0 (SHORT) or rs1 = rd (PAIR). out_last = 1. On handshake: go to IDLE.
- Latency and throughput:
  - out_valid rises the cycle after accept (1-cycle latency).
  - The next request can be accepted in the cycle after the final handshake.
  - Throughput is one sequence per (instruction count + 1) cycles.
- out_valid, out_instr and out_last are registered. They stay stable while out_valid && !out_ready, with no glitches and no change of instruction.
- out_valid is continuously high across the two words of a PAIR whenever out_ready is high.
- hi arithmetic wraps modulo 2^20. Summing the LUI result and the sign-extended lo must reproduce in_value exactly, modulo 2^32.
- Reset mid-sequence: the sequence is aborted immediately and asynchronously, with all outputs at their reset values. No partial sequence resumes afterwards.
- in_value and in_rd are ignored while in_ready is 0.

Test Plan:
- in_value=0x000007FF, rd=5 -> single word 0x7FF00293, out_last=1, valid one cycle after accept.
- in_value=0xFFFFF800, rd=1 -> 0x80000093 (ADDI x1,x0,-2048), out_last=1. Repeat with in_value=0xFFFFFFFF, rd=3 -> 0xFFF00193.
- in_value=0x12345000, rd=10 -> single LUI 0x12345537, out_last=1.
- in_value=0x12345800, rd=10 -> hi rounds up: 0x12346537 (out_last=0), then 0x80050513 (out_last=1). Repeat with SHORT_FORM=0 and in_value=0x00000005, rd=2 -> 0x00000137 then 0x00510113.
- Backpressure: in the PAIR case, hold out_ready=0 for 3 cycles on each word -> out_instr is stable, in_ready=0 throughout, exactly 2 handshakes occur. Then apply in_rd=0 with any value -> accepted, out_valid stays 0.
- Assert rst_n low while in EMIT_LO -> out_valid=0 and busy=0 in the same cycle, in_ready=1 after release. Then request 0x7FFFF800, rd=7 -> 0x800003B7 then 0x80038393.

Source files
------------

// File: rtl/immediate_materializer_if.sv
// Valid/ready request and instruction streams of the immediate materializer.
// The master drives constants in and consumes instruction words; the slave is the block.
interface immediate_materializer_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_value;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic            out_last;

  modport master (
    output in_valid, in_value, in_rd, out_ready,
    input  in_ready, out_valid, out_instr, out_last
  );

  modport slave (
    input  in_valid, in_value, in_rd, out_ready,
    output in_ready, out_valid, out_instr, out_last
  );
endinterface

// File: rtl/immediate_materializer.sv
// Turns a 32-bit constant into the shortest RV32I load sequence (ADDI, LUI, or LUI+ADDI)
// and streams the instruction words out over a valid/ready interface.
module immediate_materializer #(
  parameter int unsigned XLEN       = 32,
  parameter bit          SHORT_FORM = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  immediate_materializer_if.slave bus,
  output logic                    busy
);

  localparam int unsigned RD_W    = 5;
  localparam int unsigned IMM12_W = 12;
  localparam int unsigned IMM20_W = 20;
  localparam logic [6:0]  OP_LUI  = 7'b0110111;
  localparam logic [6:0]  OP_IMM  = 7'b0010011;

  typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO} state_t;

  state_t               state, state_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [XLEN-1:0]      instr_q, instr_d;
  logic [RD_W-1:0]      rd_q, rd_d;
  logic [IMM12_W-1:0]   lo_q, lo_d;

  logic [XLEN-1:0]      value;
  logic                 fits12;
  logic                 is_short;
  logic                 is_lui;
  logic [IMM20_W-1:0]   hi;
  logic                 accept;
  logic                 out_hs;

  function automatic logic [31:0] enc_lui(input logic [IMM20_W-1:0] imm, input logic [RD_W-1:0] rd);
    return {imm, rd, OP_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [IMM12_W-1:0] imm,
                                           input logic [RD_W-1:0] rs1,
                                           input logic [RD_W-1:0] rd);
    return {imm, rs1, 3'b000, rd, OP_IMM};
  endfunction

  // Classification; hi absorbs the borrow that sign-extending lo will subtract
  assign value    = bus.in_value;
  assign fits12   = (value[31:11] == '0) || (value[31:11] == '1);
  assign is_short = SHORT_FORM && fits12;
  assign is_lui   = !is_short && SHORT_FORM && (value[11:0] == '0);
  assign hi       = value[31:12] + IMM20_W'(value[11]);

  assign accept = bus.in_valid && (state == IDLE);
  assign out_hs = valid_q && bus.out_ready;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_last  = last_q;
  assign busy          = (state != IDLE);

  always_comb begin
    state_d = state;
    valid_d = valid_q;
    instr_d = instr_q;
    last_d  = last_q;
    rd_d    = rd_q;
    lo_d    = lo_q;
    case (state)
      IDLE: begin
        // rd == x0 requests are consumed without emitting anything
        if (accept && (bus.in_rd != '0)) begin
          rd_d    = bus.in_rd;
          lo_d    = value[11:0];
          valid_d = 1'b1;
          if (is_short) begin
            state_d = EMIT_LO;
            instr_d = enc_addi(value[11:0], '0, bus.in_rd);
            last_d  = 1'b1;
          end else begin
            state_d = EMIT_HI;
            instr_d = enc_lui(hi, bus.in_rd);
            last_d  = is_lui;
          end
        end
      end
      EMIT_HI: begin
        // last_q set here means LUI alone completes the sequence
        if (out_hs) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            instr_d = '0;
            last_d  = 1'b0;
          end else begin
            state_d = EMIT_LO;
            instr_d = enc_addi(lo_q, rd_q, rd_q);
            last_d  = 1'b1;
          end
        end
      end
      EMIT_LO: begin
        if (out_hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
          instr_d = '0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        instr_d = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      last_q  <= 1'b0;
      rd_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      lo_q    <= lo_d;
    end
  end

endmodule
